// File: rtl/spi_slave_pkg.sv
// Shared types and helpers for the multi-lane SPI slave datapath (rx now, tx later).
package spi_slave_pkg;

    typedef enum logic [1:0] {
        LANE_STD  = 2'd0,
        LANE_DUAL = 2'd1,
        LANE_QUAD = 2'd2
    } lane_mode_e;

    localparam int CMD_EDGES_DEFAULT = 8;

    function automatic logic [2:0] bits_per_edge(input lane_mode_e mode);
        case (mode)
            LANE_DUAL: return 3'd2;
            LANE_QUAD: return 3'd4;
            default:   return 3'd1;
        endcase
    endfunction

endpackage

// File: rtl/spi_lane_shifter.sv
// Combinational next-value of a 1/2/4-bit-per-edge shift register, MSB- or LSB-first.
module spi_lane_shifter
    import spi_slave_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int MAX_LANES  = 4,
    parameter bit MSB_FIRST  = 1'b1
) (
    input  logic [DATA_WIDTH-1:0] i_shreg,
    input  logic [MAX_LANES-1:0]  i_sdi,
    input  logic [2:0]            i_bits,
    input  logic                  i_en,
    output logic [DATA_WIDTH-1:0] o_next
);

    // Lanes above MAX_LANES read as zero; the caller never selects them.
    logic [3:0] w_sdi4;
    assign w_sdi4 = 4'(i_sdi);

    always_comb begin
        o_next = i_shreg;
        if (i_en) begin
            if (MSB_FIRST) begin
                case (i_bits)
                    3'd2:    o_next = {i_shreg[DATA_WIDTH-3:0], w_sdi4[1:0]};
                    3'd4:    o_next = {i_shreg[DATA_WIDTH-5:0], w_sdi4[3:0]};
                    default: o_next = {i_shreg[DATA_WIDTH-2:0], w_sdi4[0]};
                endcase
            end else begin
                case (i_bits)
                    3'd2:    o_next = {w_sdi4[1:0], i_shreg[DATA_WIDTH-1:2]};
                    3'd4:    o_next = {w_sdi4[3:0], i_shreg[DATA_WIDTH-1:4]};
                    default: o_next = {w_sdi4[0], i_shreg[DATA_WIDTH-1:1]};
                endcase
            end
        end
    end

endmodule

// File: rtl/spi_slave_rx_ml.sv
// Multi-lane SPI slave receive shifter with runtime word length, lane mode,
// optional auto-repeat and a completed-word counter. Zero latency on data/data_ready.
module spi_slave_rx_ml
    import spi_slave_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int MAX_LANES  = 4,
    parameter int CNT_WIDTH  = 8,
    parameter int CMD_EDGES  = CMD_EDGES_DEFAULT,
    parameter bit MSB_FIRST  = 1'b1,
    parameter int WCNT_WIDTH = 16
) (
    input  logic                  sclk,
    input  logic                  rstn,
    input  logic [MAX_LANES-1:0]  sdi,
    input  logic [CNT_WIDTH-1:0]  counter_in,
    input  logic                  counter_in_upd,
    input  logic [1:0]            lanes_in,
    input  logic                  repeat_en,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  data_ready,
    output logic                  running,
    output logic [WCNT_WIDTH-1:0] word_cnt
);

    logic [CNT_WIDTH-1:0]  r_counter;
    logic [CNT_WIDTH-1:0]  r_target;
    lane_mode_e            r_lanes;
    logic [DATA_WIDTH-1:0] r_shreg;
    logic                  r_running;
    logic [WCNT_WIDTH-1:0] r_word_cnt;

    logic [2:0]            w_bits_req;
    logic [2:0]            w_bits;
    logic                  w_word_end;
    logic [DATA_WIDTH-1:0] w_next;

    // A mode wider than the implemented lanes degrades to std.
    assign w_bits_req = bits_per_edge(r_lanes);
    assign w_bits     = (w_bits_req > 3'(MAX_LANES)) ? 3'd1 : w_bits_req;
    assign w_word_end = r_running && (r_counter >= r_target);

    spi_lane_shifter #(
        .DATA_WIDTH (DATA_WIDTH),
        .MAX_LANES  (MAX_LANES),
        .MSB_FIRST  (MSB_FIRST)
    ) u_shifter (
        .i_shreg (r_shreg),
        .i_sdi   (sdi),
        .i_bits  (w_bits),
        .i_en    (r_running),
        .o_next  (w_next)
    );

    always_ff @(posedge sclk or negedge rstn) begin
        if (!rstn) begin
            r_counter  <= '0;
            r_target   <= CNT_WIDTH'(CMD_EDGES - 1);
            r_lanes    <= LANE_STD;
            r_shreg    <= '0;
            r_running  <= 1'b1;
            r_word_cnt <= '0;
        end else begin
            r_shreg <= w_next;
            if (w_word_end) begin
                r_counter  <= '0;
                r_word_cnt <= r_word_cnt + 1'b1;
                r_running  <= repeat_en;
            end else if (r_running && (r_counter != '1)) begin
                r_counter <= r_counter + 1'b1;
            end
            // The strobe never clears the counter so it can land in the data_ready cycle.
            if (counter_in_upd) begin
                r_target  <= counter_in;
                r_lanes   <= (lanes_in == 2'd3) ? LANE_STD : lane_mode_e'(lanes_in);
                r_running <= 1'b1;
            end
        end
    end

    assign data       = w_next;
    assign data_ready = w_word_end;
    assign running    = r_running;
    assign word_cnt   = r_word_cnt;

endmodule

// File: tb/tb_spi_slave_rx_ml.sv
// Bench for spi_slave_rx_ml: directed table, hand sequences and randomized run vs a reference model.
module tb_spi_slave_rx_ml;

    logic        sclk = 1'b0;
    logic        rstn;
    logic [3:0]  sdi;
    logic [7:0]  counter_in;
    logic        counter_in_upd;
    logic [1:0]  lanes_in;
    logic        repeat_en;
    logic [31:0] data;
    logic        data_ready;
    logic        running;
    logic [15:0] word_cnt;

    logic [31:0] l_data;
    logic        l_data_ready;
    logic        l_running;
    logic [15:0] l_word_cnt;

    always #5 sclk = ~sclk;

    spi_slave_rx_ml dut (
        .sclk           (sclk),
        .rstn           (rstn),
        .sdi            (sdi),
        .counter_in     (counter_in),
        .counter_in_upd (counter_in_upd),
        .lanes_in       (lanes_in),
        .repeat_en      (repeat_en),
        .data           (data),
        .data_ready     (data_ready),
        .running        (running),
        .word_cnt       (word_cnt)
    );

    spi_slave_rx_ml #(.MSB_FIRST(1'b0)) dut_lsb (
        .sclk           (sclk),
        .rstn           (rstn),
        .sdi            (sdi),
        .counter_in     (counter_in),
        .counter_in_upd (counter_in_upd),
        .lanes_in       (lanes_in),
        .repeat_en      (repeat_en),
        .data           (l_data),
        .data_ready     (l_data_ready),
        .running        (l_running),
        .word_cnt       (l_word_cnt)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state (MSB-first, 4 lanes, 32-bit word)
    int          m_cnt, m_tgt, m_lanes, m_wc;
    bit          m_run;
    logic [31:0] m_sh, m_data;
    bit          m_rdy;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int k_of(input int lanes);
        return (lanes == 1) ? 2 : (lanes == 2) ? 4 : 1;
    endfunction

    task automatic model_reset();
        m_cnt = 0; m_tgt = 7; m_lanes = 0; m_run = 1'b1; m_sh = '0; m_wc = 0;
    endtask

    task automatic model_comb(input logic [3:0] s);
        int k;
        k = k_of(m_lanes);
        m_rdy = m_run && (m_cnt >= m_tgt);
        if (m_run) m_data = (m_sh << k) | (32'(s) & ((32'd1 << k) - 1));
        else       m_data = m_sh;
    endtask

    task automatic model_edge(input logic u, input logic [7:0] ci, input logic [1:0] li, input logic r);
        m_sh = m_data;
        if (m_rdy) begin
            m_cnt = 0;
            m_wc  = (m_wc + 1) % 65536;
            m_run = r;
        end else if (m_run && m_cnt < 255) begin
            m_cnt = m_cnt + 1;
        end
        if (u) begin
            m_tgt   = int'(ci);
            m_lanes = (li == 2'd3) ? 0 : int'(li);
            m_run   = 1'b1;
        end
    endtask

    task automatic step(input logic [3:0] s, input logic u, input logic [7:0] ci,
                        input logic [1:0] li, input logic r,
                        output logic rdy, output logic [31:0] dat);
        @(negedge sclk);
        sdi = s; counter_in_upd = u; counter_in = ci; lanes_in = li; repeat_en = r;
        #1;
        model_comb(s);
        chk("data", data, m_data);
        chk("data_ready", 32'(data_ready), 32'(m_rdy));
        rdy = data_ready;
        dat = data;
        @(posedge sclk);
        model_edge(u, ci, li, r);
        #1;
        chk("running", 32'(running), 32'(m_run));
        chk("word_cnt", 32'(word_cnt), 32'(m_wc));
    endtask

    task automatic do_reset();
        @(negedge sclk);
        #2;
        rstn = 1'b0; sdi = '0; counter_in_upd = 1'b0; counter_in = '0; lanes_in = '0; repeat_en = 1'b0;
        #1;
        model_reset();
        chk("rst_word_cnt", 32'(word_cnt), 32'd0);
        chk("rst_running", 32'(running), 32'd1);
        chk("rst_data_ready", 32'(data_ready), 32'd0);
        chk("rst_data", data, 32'd0);
        @(posedge sclk);
        #1;
        rstn = 1'b1;
    endtask

    typedef struct {
        logic [3:0] sdi;
        logic       upd;
        logic [7:0] cin;
        logic [1:0] lin;
        logic       exp_rdy;
    } vec_t;

    vec_t        tbl[16];
    logic        rdy;
    logic [31:0] dat;
    logic [7:0]  a5;
    logic [31:0] words[3];
    logic [31:0] w;
    logic        r_rep;

    initial begin
        rstn = 1'b1; sdi = '0; counter_in = '0; counter_in_upd = 1'b0; lanes_in = '0; repeat_en = 1'b0;

        a5 = 8'hA5;
        for (int i = 0; i < 8; i++)
            tbl[i] = '{sdi: {3'b000, a5[7-i]}, upd: (i == 7), cin: 8'd7, lin: 2'd2, exp_rdy: (i == 7)};
        for (int i = 0; i < 8; i++)
            tbl[8+i] = '{sdi: 4'(i + 1), upd: 1'b0, cin: 8'd0, lin: 2'd0, exp_rdy: (i == 7)};

        do_reset();

        // std 0xA5 then quad 0x12345678 with the strobe in the data_ready cycle
        for (int i = 0; i < 16; i++) begin
            step(tbl[i].sdi, tbl[i].upd, tbl[i].cin, tbl[i].lin, 1'b0, rdy, dat);
            chk($sformatf("tbl_rdy[%0d]", i), 32'(rdy), 32'(tbl[i].exp_rdy));
            if (i == 7)  chk("a5_byte", 32'(dat[7:0]), 32'hA5);
            if (i == 15) chk("quad_word", dat, 32'h12345678);
        end
        chk("word_cnt_after_quad", 32'(word_cnt), 32'd2);
        chk("running_after_quad", 32'(running), 32'd0);

        // dual, 16 edges per word, auto-repeat, three back-to-back words
        words[0] = 32'hDEADBEEF; words[1] = 32'h0; words[2] = 32'hFFFFFFFF;
        step(4'h0, 1'b1, 8'd15, 2'd1, 1'b1, rdy, dat);
        for (int wi = 0; wi < 3; wi++) begin
            w = words[wi];
            for (int e = 0; e < 16; e++) begin
                step(4'(w >> (30 - 2 * e)) & 4'h3, 1'b0, 8'd0, 2'd0, 1'b1, rdy, dat);
                if (e == 15) begin
                    chk($sformatf("dual_rdy[%0d]", wi), 32'(rdy), 32'd1);
                    chk($sformatf("dual_word[%0d]", wi), dat, words[wi]);
                end
            end
        end
        chk("word_cnt_after_dual", 32'(word_cnt), 32'd5);
        chk("running_after_dual", 32'(running), 32'd1);

        // mid-word shortening: counter already past the new target
        step(4'h1, 1'b1, 8'd31, 2'd0, 1'b0, rdy, dat);
        for (int e = 0; e < 10; e++) step(4'(e & 1), 1'b0, 8'd0, 2'd0, 1'b0, rdy, dat);
        step(4'h1, 1'b1, 8'd5, 2'd0, 1'b0, rdy, dat);
        chk("mid_upd_edge_rdy", 32'(rdy), 32'd0);
        step(4'h0, 1'b0, 8'd0, 2'd0, 1'b0, rdy, dat);
        chk("mid_end_rdy", 32'(rdy), 32'd1);
        step(4'h0, 1'b0, 8'd0, 2'd0, 1'b0, rdy, dat);
        chk("mid_after_rdy", 32'(rdy), 32'd0);

        // LSB-first build: 0x01 lands in the top byte
        do_reset();
        for (int e = 0; e < 8; e++) step((e == 0) ? 4'h1 : 4'h0, 1'b0, 8'd0, 2'd0, 1'b0, rdy, dat);
        chk("lsb_top_byte", 32'(l_data[31:24]), 32'h01);
        chk("lsb_word_cnt", 32'(l_word_cnt), 32'd1);
        chk("lsb_running", 32'(l_running), 32'd0);

        // reset mid-word aborts, next word uses the command length again
        step(4'h1, 1'b1, 8'd20, 2'd2, 1'b0, rdy, dat);
        for (int e = 0; e < 5; e++) step(4'hF, 1'b0, 8'd0, 2'd0, 1'b0, rdy, dat);
        do_reset();
        for (int e = 0; e < 8; e++) begin
            step(4'(e & 1), 1'b0, 8'd0, 2'd0, 1'b0, rdy, dat);
            chk($sformatf("post_rst_rdy[%0d]", e), 32'(rdy), (e == 7) ? 32'd1 : 32'd0);
        end
        chk("post_rst_byte", 32'(dat[7:0]), 32'h55);
        chk("post_rst_word_cnt", 32'(word_cnt), 32'd1);

        // randomized traffic against the model
        r_rep = 1'b0;
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 149) == 0) begin
                do_reset();
            end else begin
                logic u;
                u = ($urandom_range(0, 7) == 0);
                if (u) r_rep = 1'($urandom_range(0, 1));
                step(4'($urandom), u, 8'($urandom_range(0, 20)), 2'($urandom_range(0, 3)),
                     r_rep, rdy, dat);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
